// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode hazard and PC sequencing controller: load-use stalls, branch flushes, two-word
// instructions and, when FD_CTRL_INT_EN is defined, interrupt drain and vector entry.
module fetch_decode_ctrl #(
  parameter int unsigned OPW          = 5,
  parameter int unsigned REGW         = 3,
  parameter logic [1:0]  IMM_CLASS    = 2'b10,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode_decode,
  input  logic [REGW-1:0] rs_decode,
  input  logic [REGW-1:0] rd_decode,
  input  logic            decode_valid,
  input  logic [REGW-1:0] rd_ex,
  input  logic            mem_read_ex,
  input  logic            branch_taken_ex,
  input  logic            int_req,
  output logic            pc_write_en,
  output logic            ifid_write_en,
  output logic            ifid_flush,
  output logic            bubble_ex,
  output logic            imm_capture,
  output logic [1:0]      pc_sel,
  output logic            int_ack
);

`ifdef FD_CTRL_INT_EN
  typedef enum logic [2:0] {StRun, StImm, StFlush, StIntDrain, StIntJump} state_e;
  logic [2:0] drain_cnt;
`else
  typedef enum logic [1:0] {StRun, StImm, StFlush} state_e;
`endif

  state_e state;
  logic   load_use;
  logic   two_word;
  logic   int_take;

  assign load_use = mem_read_ex && decode_valid &&
                    ((rd_ex == rs_decode) || (rd_ex == rd_decode));
  assign two_word = decode_valid && (opcode_decode[OPW-1 -: 2] == IMM_CLASS);

`ifdef FD_CTRL_INT_EN
  assign int_take = int_req;
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign int_take       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StRun;
`ifdef FD_CTRL_INT_EN
      drain_cnt <= '0;
`endif
    end else begin
      case (state)
        StRun: begin
          if (branch_taken_ex) begin
            state <= StFlush;
`ifdef FD_CTRL_INT_EN
          end else if (int_take) begin
            state     <= StIntDrain;
            drain_cnt <= 3'(DRAIN_CYCLES - 1);
`endif
          end else if (!load_use && two_word) begin
            state <= StImm;
          end
        end
        // The word in decode is the immediate, so only a branch can redirect.
        StImm:   state <= branch_taken_ex ? StFlush : StRun;
        StFlush: state <= StRun;
`ifdef FD_CTRL_INT_EN
        StIntDrain: begin
          if (drain_cnt == 3'd0) begin
            state <= StIntJump;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        StIntJump: state <= StRun;
`endif
        default: state <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    bubble_ex     = 1'b0;
    imm_capture   = 1'b0;
    pc_sel        = 2'b00;
    int_ack       = 1'b0;
    case (state)
      StRun: begin
        if (branch_taken_ex) begin
          ifid_flush = 1'b1;
          bubble_ex  = 1'b1;
          pc_sel     = 2'b01;
        end else if (int_take) begin
          pc_write_en = 1'b0;
          pc_sel      = 2'b11;
          ifid_flush  = 1'b1;
        end else if (load_use) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          pc_sel        = 2'b11;
          bubble_ex     = 1'b1;
        end
      end
      StImm: begin
        imm_capture = 1'b1;
        bubble_ex   = 1'b1;
        if (branch_taken_ex) begin
          ifid_flush = 1'b1;
          pc_sel     = 2'b01;
        end
      end
      StFlush: ifid_flush = 1'b1;
`ifdef FD_CTRL_INT_EN
      StIntDrain: begin
        pc_write_en = 1'b0;
        pc_sel      = 2'b11;
        ifid_flush  = 1'b1;
        bubble_ex   = 1'b1;
      end
      StIntJump: begin
        pc_sel     = 2'b10;
        ifid_flush = 1'b1;
        int_ack    = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset forces a frozen, fully flushed pipeline regardless of state.
    if (!rst_n) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      bubble_ex     = 1'b1;
      imm_capture   = 1'b0;
      pc_sel        = 2'b11;
      int_ack       = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Randomized scoreboard bench for fetch_decode_ctrl against a slot-counting reference model.
module tb_fetch_decode_ctrl;
  localparam int unsigned OPW   = 5;
  localparam int unsigned REGW  = 3;
  localparam logic [1:0]  IMMC  = 2'b10;
  localparam int unsigned DRAIN = 3;
`ifdef FD_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_we;
    logic       ifid_we;
    logic       flush;
    logic       bub;
    logic       imm;
    logic       ack;
    logic [1:0] sel;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [OPW-1:0]  opcode_decode;
  logic [REGW-1:0] rs_decode, rd_decode, rd_ex;
  logic            decode_valid, mem_read_ex, branch_taken_ex, int_req;
  logic            pc_write_en, ifid_write_en, ifid_flush, bubble_ex, imm_capture, int_ack;
  logic [1:0]      pc_sel;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  // Reference model state: pending slots rather than an FSM encoding.
  bit m_flush = 0;
  bit m_imm = 0;
  int m_drain = 0;
  bit m_jump = 0;

  fetch_decode_ctrl #(
    .OPW(OPW), .REGW(REGW), .IMM_CLASS(IMMC), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode_decode(opcode_decode), .rs_decode(rs_decode),
    .rd_decode(rd_decode), .decode_valid(decode_valid), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .int_req(int_req),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .bubble_ex(bubble_ex), .imm_capture(imm_capture), .pc_sel(pc_sel), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic model(input logic r, br, ir, mr, dv, input logic [OPW-1:0] op,
                       input logic [REGW-1:0] rs, rd, rdex, output exp_t e);
    logic [OPW-1:0] opv;
    bit lu, tw, in_imm;
    e = '{pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0, bub: 1'b0, imm: 1'b0, ack: 1'b0,
          sel: 2'b00};
    opv = op;
    lu  = mr && dv && (rdex == rs || rdex == rd);
    tw  = dv && (opv[OPW-1:OPW-2] == IMMC);
    if (!r) begin
      e = '{pc_we: 1'b0, ifid_we: 1'b0, flush: 1'b1, bub: 1'b1, imm: 1'b0, ack: 1'b0,
            sel: 2'b11};
      m_flush = 0; m_imm = 0; m_drain = 0; m_jump = 0;
    end else if (m_drain > 0) begin
      e.pc_we = 1'b0; e.sel = 2'b11; e.flush = 1'b1; e.bub = 1'b1;
      m_drain--;
    end else if (m_jump) begin
      e.sel = 2'b10; e.flush = 1'b1; e.ack = 1'b1;
      m_jump = 0;
    end else if (m_flush) begin
      e.flush = 1'b1;
      m_flush = 0;
    end else begin
      in_imm = m_imm;
      m_imm  = 0;
      if (in_imm) begin e.imm = 1'b1; e.bub = 1'b1; end
      if (br) begin
        e.flush = 1'b1; e.bub = 1'b1; e.sel = 2'b01;
        m_flush = 1;
      end else if (!in_imm) begin
        if (INT_EN && ir) begin
          e.pc_we = 1'b0; e.sel = 2'b11; e.flush = 1'b1;
          m_drain = DRAIN; m_jump = 1;
        end else if (lu) begin
          e.pc_we = 1'b0; e.ifid_we = 1'b0; e.sel = 2'b11; e.bub = 1'b1;
        end else if (tw) begin
          m_imm = 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs just after the edge; reset changes here are mid-cycle.
  task automatic step(input logic r, br, ir, mr, dv, input logic [OPW-1:0] op,
                      input logic [REGW-1:0] rs, rd, rdex);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; branch_taken_ex = br; int_req = ir; mem_read_ex = mr; decode_valid = dv;
    opcode_decode = op; rs_decode = rs; rd_decode = rd; rd_ex = rdex;
    model(r, br, ir, mr, dv, op, rs, rd, rdex, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd7);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pc_we: pc_write_en, ifid_we: ifid_write_en, flush: ifid_flush, bub: bubble_ex,
              imm: imm_capture, ack: int_ack, sel: pc_sel};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got pcwe=%b ifwe=%b fl=%b bub=%b imm=%b ack=%b sel=%b want pcwe=%b ifwe=%b fl=%b bub=%b imm=%b ack=%b sel=%b",
                   $time, a.pc_we, a.ifid_we, a.flush, a.bub, a.imm, a.ack, a.sel,
                   e.pc_we, e.ifid_we, e.flush, e.bub, e.imm, e.ack, e.sel);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; branch_taken_ex = 1'b0; int_req = 1'b0; mem_read_ex = 1'b0;
    decode_valid = 1'b0; opcode_decode = '0; rs_decode = '0; rd_decode = '0; rd_ex = '0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd7);
    idle(2);
    // Load-use for one cycle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00001, 3'd3, 3'd5, 3'd3);
    idle(2);
    // Branch together with load-use.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 3'd3, 3'd5, 3'd3);
    idle(2);
    // Two-word instruction.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10001, 3'd1, 3'd2, 3'd7);
    idle(2);
    // Interrupt entry, then a branch during the drain.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd7);
    idle(5);
    // Interrupt against a two-word instruction, then reset mid-drain.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10101, 3'd0, 3'd0, 3'd7);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd7);
    idle(3);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) != 0, $urandom_range(9) == 0, $urandom_range(19) == 0,
           $urandom_range(2) == 0, $urandom_range(3) != 0, OPW'($urandom),
           REGW'($urandom), REGW'($urandom), REGW'($urandom));
    end
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
# fetch_decode_ctrl

Hazard and sequencing controller for the fetch→decode pipeline register and the PC. Every cycle it decides whether the PC and the fetch/decode register advance, hold, or are flushed, and which PC source is selected. It handles load-use stalls, taken-branch flushes, two-word (immediate) instructions and, optionally, interrupt entry. It sits beside the fetch stage and drives the write-enable and flush controls of the fetch/decode register and the PC mux.

## Interface
- OPW, 5, opcode width
- REGW, 3, register index width
- IMM_CLASS, 2'b10, value of opcode[OPW-1:OPW-2] that marks a two-word instruction
- DRAIN_CYCLES, 3, cycles waited for pipeline drain before the interrupt jump (1..7)
- clk  in  1  clock; state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- opcode_decode  in  OPW  opcode currently in the decode stage
- rs_decode, rd_decode  in  REGW  source registers read by decode
- decode_valid  in  1  decode holds a real instruction, not a bubble
- rd_ex  in  REGW  destination register of the execute stage
- mem_read_ex  in  1  execute-stage instruction is a load
- branch_taken_ex  in  1  branch resolved taken in execute
- int_req  in  1  level interrupt request
- pc_write_en  out  1  PC loads next value
- ifid_write_en  out  1  fetch/decode register captures
- ifid_flush  out  1  fetch/decode register loads a bubble
- bubble_ex  out  1  decode→execute register loads a bubble
- imm_capture  out  1  current fetched word is an immediate
- pc_sel  out  2  00 PC+1, 01 branch target, 10 interrupt vector, 11 hold
- int_ack  out  1  one-cycle interrupt acknowledge

## Operation
- States: RUN, IMM, FLUSH, INT_DRAIN, INT_JUMP.
- Outputs are combinational from state and inputs. State and the drain counter are registered.
- Priority in RUN, highest first: branch_taken_ex > int_req > load-use > two-word > normal.
- Branch in RUN: ifid_flush=1, bubble_ex=1, pc_sel=01, pc_write_en=1. Next state is FLUSH.
- FLUSH: ifid_flush=1, pc_sel=00. Then RUN. This kills the two wrong-path slots.
- Load-use is defined as mem_read_ex && decode_valid && (rd_ex==rs_decode || rd_ex==rd_decode).
  - On load-use: pc_write_en=0, ifid_write_en=0, pc_sel=11, bubble_ex=1. State stays RUN.
  - The stall lasts exactly as long as the condition holds, normally one cycle.
- Two-word instruction is defined as decode_valid && opcode_decode[OPW-1:OPW-2]==IMM_CLASS with no higher-priority event.
  - Response: normal advance. Next state is IMM.
- IMM: imm_capture=1, bubble_ex=1 (the immediate word never decodes as an instruction), normal advance. Then RUN.
  - A branch in IMM takes the branch path; imm_capture is still 1 that cycle.
- Interrupt in RUN: pc_write_en=0, pc_sel=11, ifid_flush=1. The counter loads DRAIN_CYCLES-1. Next state is INT_DRAIN.
- INT_DRAIN: PC is held, ifid_flush=1, bubble_ex=1, and the counter decrements. At 0 the next state is INT_JUMP.
  - A branch during INT_DRAIN is ignored, because the flush already covers it.
- INT_JUMP: pc_sel=10, pc_write_en=1, ifid_flush=1, int_ack=1. Then RUN.
- int_req is not re-sampled until the state returns to RUN.

## Timing
- Reset (rst_n=0, asynchronous): state RUN, counter 0.
  - Outputs while in reset: pc_write_en=0, ifid_write_en=0, ifid_flush=1, bubble_ex=1, imm_capture=0, pc_sel=11, int_ack=0.
  - Release is synchronous to the next posedge. The first RUN cycle after release has pc_sel=00.
- Default RUN outputs: pc_write_en=1, ifid_write_en=1, ifid_flush=0, bubble_ex=0, pc_sel=00, int_ack=0, imm_capture=0.
- Latencies:
  - Branch costs 2 flushed slots.
  - Load-use costs 1 bubble per cycle the condition holds.
  - Interrupt entry is DRAIN_CYCLES+1 cycles from acceptance to vector fetch.
- ifid_flush has priority over ifid_write_en. The register must treat flush as "write bubble" whenever it is asserted.
- Simultaneous events resolve as follows:
  - Load-use and branch: the branch wins, and stall outputs are suppressed.
  - int_req and two-word: the interrupt wins. The two-word instruction is flushed and refetched after return.
- Reset asserted mid-drain aborts the sequence immediately.

## Configuration
- FD_CTRL_INT_EN defined: interrupt states, counter, int_req and int_ack logic present as described.
- FD_CTRL_INT_EN undefined:
  - INT_DRAIN and INT_JUMP and the counter are removed.
  - int_req is ignored and int_ack is tied 0.
  - pc_sel never takes 10.

## Test plan
- Reset: hold rst_n=0 mid-cycle → outputs go to their reset values immediately. After release, pc_sel=00 and ifid_write_en=1 on the first cycle.
- Load-use: mem_read_ex=1, rd_ex=3, rs_decode=3, decode_valid=1 for one cycle → pc_write_en=0, ifid_write_en=0, bubble_ex=1 for exactly 1 cycle. Normal advance follows.
- Branch plus load-use in the same cycle → pc_sel=01, ifid_flush=1 for 2 consecutive cycles, and no stall.
- Two-word: opcode_decode=5'b10001, decode_valid=1 → the next cycle has imm_capture=1 and bubble_ex=1, then RUN.
- Interrupt (macro defined, DRAIN_CYCLES=3): int_req=1 in RUN → 3 cycles of held PC with flush, then pc_sel=10 and int_ack=1 for 1 cycle. Re-run with the macro undefined → int_ack stays 0.
